// File: rtl/mem_layout_pkg.sv
// Shared defaults, state encoding and helpers for the DAC output stage.
package mem_layout_pkg;

  localparam int DAC_FIFO_DEPTH     = 8;
  localparam int DAC_PREFILL        = 4;
  localparam int UNDERRUN_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_STREAM  = 2'd2
  } dac_out_state_t;

  function automatic logic [UNDERRUN_CNT_WIDTH-1:0] sat_inc(
    input logic [UNDERRUN_CNT_WIDTH-1:0] v
  );
    logic [UNDERRUN_CNT_WIDTH-1:0] one;
    one = {{(UNDERRUN_CNT_WIDTH-1){1'b0}}, 1'b1};
    return (v == {UNDERRUN_CNT_WIDTH{1'b1}}) ? v : (v + one);
  endfunction

endpackage

// File: rtl/dac_batch_stream_out_batch_fifo.sv
// batch_fifo: circular buffer of batches with a registered head-of-queue read port,
// occupancy output and synchronous flush.
module batch_fifo
  import mem_layout_pkg::*;
#(
  parameter int DEPTH = DAC_FIFO_DEPTH,
  parameter int WIDTH = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(32'd1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(32'd1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] r_head;
  logic [AW-1:0]    w_rd_ptr_nxt;
  logic             w_wr_en;
  logic             w_rd_en;

  assign w_wr_en      = i_push & ~i_flush & (r_level != LVL_FULL);
  assign w_rd_en      = i_pop & ~i_flush & (r_level != {LW{1'b0}});
  assign w_rd_ptr_nxt = w_rd_en ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;

  // storage array, written at the tail
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // pointers wrap modulo DEPTH; the level's extra MSB separates full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {LW{1'b0}};
    end else if (i_flush) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_level  <= {LW{1'b0}};
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // registered head: write-through when the slot being filled becomes the new head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= {WIDTH{1'b0}};
    end else if (i_flush) begin
      r_head <= {WIDTH{1'b0}};
    end else if (w_wr_en && (r_wr_ptr == w_rd_ptr_nxt)) begin
      r_head <= i_wr_data;
    end else begin
      r_head <= r_mem[w_rd_ptr_nxt];
    end
  end

  assign o_head  = r_head;
  assign o_level = r_level;

endmodule

// File: rtl/dac_batch_stream_out.sv
// dac_batch_stream_out: buffers generator batches and streams them to the DAC over AXI-Stream.
// Build option DAC_UNDERRUN_HOLD_EN: underrun fill repeats the last real batch instead of zeros.
module dac_batch_stream_out
  import mem_layout_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int BATCH_WIDTH  = 256,
  parameter int FIFO_DEPTH   = DAC_FIFO_DEPTH,
  parameter int PREFILL      = DAC_PREFILL
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          stream_en,
  input  logic                          clr_status,
  input  logic [BATCH_WIDTH-1:0]        dac_batch,
  input  logic                          valid_dac_batch,
  output logic                          dac0_rdy,
  output logic [BATCH_WIDTH-1:0]        m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [UNDERRUN_CNT_WIDTH-1:0] underrun_cnt,
  output logic                          overflow,
  output logic                          streaming
);
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;
  localparam int BATCH_SIZE = BATCH_WIDTH / SAMPLE_WIDTH;
  localparam logic [BATCH_WIDTH-1:0] ZERO_BATCH = {BATCH_SIZE{{SAMPLE_WIDTH{1'b0}}}};
  localparam logic [LW-1:0] LVL_ONE     = LW'(32'd1);
  localparam logic [LW-1:0] LVL_PREFILL = LW'(PREFILL);
  localparam logic [LW-1:0] LVL_FULL    = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_RDY_MAX = LW'(FIFO_DEPTH - 2);

  dac_out_state_t r_state;
  dac_out_state_t w_state_nxt;

  logic                          r_rdy;
  logic                          r_tvalid;
  logic [BATCH_WIDTH-1:0]        r_tdata;
  logic [UNDERRUN_CNT_WIDTH-1:0] r_underrun;
  logic                          r_overflow;
  logic                          r_streaming;

  logic [LW-1:0]          w_level;
  logic [LW-1:0]          w_level_nxt;
  logic [BATCH_WIDTH-1:0] w_head;
  logic [BATCH_WIDTH-1:0] w_fill;
  logic                   w_flush;
  logic                   w_empty;
  logic                   w_beat;
  logic                   w_start;
  logic                   w_real_pop;
  logic                   w_fill_beat;
  logic                   w_push;
  logic                   w_drop;

  assign w_flush     = ~stream_en | (r_state == ST_IDLE);
  assign w_empty     = (w_level == {LW{1'b0}});
  assign w_beat      = r_tvalid & m_axis_tready;
  assign w_start     = stream_en & (r_state == ST_PREFILL) & (w_level >= LVL_PREFILL);
  assign w_real_pop  = w_start | (stream_en & (r_state == ST_STREAM) & w_beat & ~w_empty);
  assign w_fill_beat = stream_en & (r_state == ST_STREAM) & w_beat & w_empty;
  assign w_push      = valid_dac_batch & ~w_flush & (w_level < LVL_FULL);
  assign w_drop      = valid_dac_batch & ~w_flush & ~(w_level < LVL_FULL);

  batch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BATCH_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (w_flush),
    .i_push    (w_push),
    .i_wr_data (dac_batch),
    .i_pop     (w_real_pop),
    .o_head    (w_head),
    .o_level   (w_level)
  );

`ifdef DAC_UNDERRUN_HOLD_EN
  logic [BATCH_WIDTH-1:0] r_last_real;

  // last real batch put on the bus, forgotten on reset or whenever the stage idles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_real <= ZERO_BATCH;
    end else if (w_flush) begin
      r_last_real <= ZERO_BATCH;
    end else if (w_real_pop) begin
      r_last_real <= w_head;
    end else begin
      r_last_real <= r_last_real;
    end
  end

  assign w_fill = r_last_real;
`else
  assign w_fill = ZERO_BATCH;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state: dropping the enable always returns to IDLE
  always_comb begin
    w_state_nxt = r_state;
    if (!stream_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    w_state_nxt = ST_PREFILL;
        ST_PREFILL: begin
          if (w_level >= LVL_PREFILL) begin
            w_state_nxt = ST_STREAM;
          end else begin
            w_state_nxt = ST_PREFILL;
          end
        end
        ST_STREAM:  w_state_nxt = ST_STREAM;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // occupancy one cycle ahead, feeding the throttle
  always_comb begin
    w_level_nxt = w_level;
    if (w_flush) begin
      w_level_nxt = {LW{1'b0}};
    end else begin
      case ({w_push, w_real_pop})
        2'b10:   w_level_nxt = w_level + LVL_ONE;
        2'b01:   w_level_nxt = w_level - LVL_ONE;
        default: w_level_nxt = w_level;
      endcase
    end
  end

  // AXI-Stream output register and generator throttle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tvalid    <= 1'b0;
      r_tdata     <= ZERO_BATCH;
      r_rdy       <= 1'b0;
      r_streaming <= 1'b0;
    end else begin
      if (w_flush) begin
        r_tvalid <= 1'b0;
        r_tdata  <= ZERO_BATCH;
      end else if (w_real_pop) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_head;
      end else if (w_fill_beat) begin
        r_tdata  <= w_fill;
      end
      r_rdy       <= ~w_flush & (w_level_nxt <= LVL_RDY_MAX);
      r_streaming <= (w_state_nxt == ST_STREAM);
    end
  end

  // status: a clear in the same cycle as an event wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun <= {UNDERRUN_CNT_WIDTH{1'b0}};
      r_overflow <= 1'b0;
    end else if (clr_status) begin
      r_underrun <= {UNDERRUN_CNT_WIDTH{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_fill_beat) begin
        r_underrun <= sat_inc(r_underrun);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign dac0_rdy      = r_rdy;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign fifo_level    = w_level;
  assign underrun_cnt  = r_underrun;
  assign overflow      = r_overflow;
  assign streaming     = r_streaming;

endmodule

// File: doc/dac_batch_stream_out.md
# dac_batch_stream_out

Output stage directly downstream of the sample generator. Absorbs its unthrottled `dac_batch`/`valid_dac_batch` stream into a small FIFO and drives an AXI-Stream master toward the RF DAC tile. Generates the `dac0_rdy` throttle the generator's pipeline runs on, and fills underruns with a defined pattern. Exposes underrun and overflow status to the PS.

## Interface
- `SAMPLE_WIDTH`, 16, bits per DAC sample
- `BATCH_WIDTH`, 256, bits per batch (BATCH_SIZE = BATCH_WIDTH/SAMPLE_WIDTH)
- `FIFO_DEPTH`, 8, batch entries; power of two, >= 4
- `PREFILL`, 4, entries required before streaming starts; 1..FIFO_DEPTH-1
- `clk`  in  1  sole clock
- `rst_n`  in  1  asynchronous, active-low reset
- `stream_en`  in  1  PS enable; level-sensitive
- `clr_status`  in  1  single-cycle pulse; clears `underrun_cnt` and `overflow`
- `dac_batch`  in  BATCH_WIDTH  batch from generator
- `valid_dac_batch`  in  1  batch qualifier; no backpressure on this side
- `dac0_rdy`  out  1  registered; generator may advance
- `m_axis_tdata`  out  BATCH_WIDTH  batch to DAC
- `m_axis_tvalid`  out  1  registered
- `m_axis_tready`  in  1  DAC accepts
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy
- `underrun_cnt`  out  16  saturating count of fill beats
- `overflow`  out  1  sticky; a valid batch was dropped
- `streaming`  out  1  high in STREAM state

## Operation
- States: IDLE, PREFILL, STREAM.
- IDLE:
  - FIFO held empty; `m_axis_tvalid`=0; `dac0_rdy`=0.
  - `stream_en`=1 -> PREFILL.
- PREFILL:
  - `dac0_rdy` follows the throttle rule; writes accepted; `m_axis_tvalid`=0.
  - Level >= PREFILL -> STREAM.
- STREAM:
  - `m_axis_tvalid`=1 continuously.
  - On each beat (tvalid & tready): if the FIFO is non-empty, pop and present the next entry. If it is empty, present the fill batch and increment `underrun_cnt` (saturate at 0xFFFF).
  - Fill beats never leave STREAM.
- `stream_en`=0 in any state -> IDLE next cycle. FIFO is flushed and the in-flight output is dropped.
- Throttle rule: `dac0_rdy` is registered high iff next-cycle level <= FIFO_DEPTH-2. This guarantees room for one write while it is high.
- Write accepted iff `valid_dac_batch` and level < FIFO_DEPTH. Otherwise the batch is dropped and `overflow` is set. This is only reachable through a protocol violation.
- Simultaneous push and pop: level unchanged. Push into an empty FIFO during a fill beat is not visible until the next beat.
- `clr_status` coinciding with a new underrun or overflow: the clear wins that cycle, and the event counts from the next cycle.

## Timing
- Reset values:
  - all state -> IDLE
  - `dac0_rdy`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0
  - `fifo_level`=0, `underrun_cnt`=0, `overflow`=0, `streaming`=0
- `dac0_rdy` rises 1 cycle after entering PREFILL.
- Write in cycle N raises `fifo_level` in N+1.
- PREFILL->STREAM 1 cycle after the level reaches PREFILL. First tdata is the oldest entry, registered.
- Output-register model: `m_axis_tdata` is updated on a handshake; data changes only on tvalid & tready.
- Reset asserted mid-stream forces outputs to reset values immediately (asynchronous). Release takes effect on the next clk edge.
- Pointers wrap modulo FIFO_DEPTH. Level uses the extra MSB to distinguish full from empty.

## Configuration
- `DAC_UNDERRUN_HOLD_EN` defined: the fill batch is the last real batch presented (zeros if none since reset or IDLE).
- Undefined: the fill batch is all zeros (DAC mid-scale for offset-binary is not applied; zeros as-is).
- Underrun counting is identical in both builds.

## Structure
- In `mem_layout_pkg`:
  - `DAC_FIFO_DEPTH` and `DAC_PREFILL` defaults
  - enum `dac_out_state_t` {IDLE, PREFILL, STREAM}
  - `UNDERRUN_CNT_WIDTH` = 16
- Sub-module `batch_fifo`: synchronous circular buffer of FIFO_DEPTH x BATCH_WIDTH with registered read port, level output, and flush input. FSM, throttle, fill mux and status counters stay in the top.

## Test plan
- Reset, `stream_en`=1, 4 valid batches 0x1..0x4, tready=1 -> STREAM entered; tdata 0x1,0x2,0x3,0x4 in order; `underrun_cnt`=0.
- Generator valid held continuously, tready=1 -> `fifo_level` never exceeds FIFO_DEPTH-1; `overflow` stays 0; no batch lost or duplicated.
- tready=0 for 20 cycles during streaming -> `dac0_rdy` deasserts once level reaches FIFO_DEPTH-1; tdata holds; nothing dropped; resumes in order.
- Source stops after batch 0xA5 -> each subsequent beat increments `underrun_cnt`. With `DAC_UNDERRUN_HOLD_EN` tdata holds 0xA5; without it, tdata=0. `clr_status` returns the count to 0.
- Forced valid with FIFO full -> `overflow`=1 and sticky until `clr_status`.
- `stream_en` drop mid-stream, then async `rst_n` pulse -> IDLE, level 0, tvalid 0; re-enable requires a fresh prefill.
